// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue between the instruction-memory port and the
// decode stage. Sequential fetch requests are issued ahead of decode and up to
// DEPTH entries of {pc, instr, e_code} are buffered, so decode stalls are
// absorbed without re-fetching. A redirect flushes the queue and restarts
// fetch at redirect_pc. Responses to requests issued before a redirect are
// counted in a drop counter and discarded when they arrive. Fetch addresses
// that are misaligned or outside [ADDR_LO, ADDR_HI] produce an entry tagged
// EXC_ADEL with instr = 0 instead of a memory request.
//
// Optional feature macro: FQ_BYPASS_EN
//   When defined, a live response that finds the queue empty while d_ready=1
//   is forwarded combinationally to d_* in the same cycle and not stored.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   mips_rst       synchronous active-low reset
//   redirect       flush queue and restart fetch at redirect_pc
//   redirect_pc    new fetch address
//   imem_req_*     fetch request (valid/ready handshake), address
//   imem_rsp_*     in-order memory response, instruction word
//   d_valid/d_*    head entry presented to decode; zeros when empty
//   d_ready        decode consumes the head entry
//   fq_count       number of occupied queue entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     AW       = 32,
    parameter int unsigned     DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = 32'h0000_3000,
    parameter logic [AW-1:0]   ADDR_LO  = 32'h0000_3000,
    parameter logic [AW-1:0]   ADDR_HI  = 32'h0000_6fff,
    parameter logic [4:0]      EXC_ADEL = 5'd4
) (
    input  logic                   clk,
    input  logic                   mips_rst,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    output logic                   imem_req_valid,
    output logic [AW-1:0]          imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [DW-1:0]          imem_rsp_data,
    output logic                   d_valid,
    output logic [DW-1:0]          d_instr,
    output logic [AW-1:0]          d_pc,
    output logic [4:0]             d_e_code,
    input  logic                   d_ready,
    output logic [$clog2(DEPTH):0] fq_count
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    // Drop counter accumulates across back-to-back redirects; extra headroom
    // covers several flushes whose stale responses are still in the memory.
    localparam int unsigned DCW = PW + 4;
    localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

    // Queue storage
    logic [AW-1:0] pc_mem    [DEPTH];
    logic [DW-1:0] instr_mem [DEPTH];
    logic [4:0]    ec_mem    [DEPTH];
    // PCs of requests in flight, in issue order
    logic [AW-1:0] if_pc_mem [DEPTH];

    logic [AW-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  out_q, out_d;
    logic [DCW-1:0] drop_q, drop_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  if_rd_q, if_rd_d, if_wr_q, if_wr_d;

    logic           pc_legal, slot_avail, req_fire, exc_push;
    logic           rsp_drop, rsp_live, head_valid, bypass;
    logic           pop, push_rsp, push;
    logic [CW:0]    slot_sum;
    logic [AW-1:0]  w_pc;
    logic [DW-1:0]  w_instr;
    logic [4:0]     w_ec;

    always_comb begin
        pc_legal   = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q >= ADDR_LO) &&
                     (fetch_pc_q <= ADDR_HI);
        slot_sum   = {1'b0, count_q} + {1'b0, out_q};
        slot_avail = slot_sum < DepthW;

        imem_req_valid = mips_rst && !redirect && pc_legal && slot_avail;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        // An AdEL entry waits for in-flight responses to drain so that it
        // lands in the queue behind them and the queue keeps one write port.
        exc_push = mips_rst && !redirect && !pc_legal && slot_avail && (out_q == '0);

        rsp_drop = imem_rsp_valid && (drop_q != '0);
        rsp_live = imem_rsp_valid && (drop_q == '0) && (out_q != '0);

        head_valid = (count_q != '0);
`ifdef FQ_BYPASS_EN
        bypass = rsp_live && !redirect && !head_valid && d_ready;
`else
        bypass = 1'b0;
`endif

        pop      = head_valid && d_ready;
        push_rsp = rsp_live && !redirect && !bypass;
        push     = push_rsp || exc_push;

        if (push_rsp) begin
            w_pc    = if_pc_mem[if_rd_q];
            w_instr = imem_rsp_data;
            w_ec    = 5'd0;
        end else begin
            w_pc    = fetch_pc_q;
            w_instr = '0;
            w_ec    = EXC_ADEL;
        end
    end

    // Head of queue to decode; all-zero when nothing is presented
    always_comb begin
        d_valid  = 1'b0;
        d_pc     = '0;
        d_instr  = '0;
        d_e_code = '0;
        if (head_valid) begin
            d_valid  = 1'b1;
            d_pc     = pc_mem[rd_ptr_q];
            d_instr  = instr_mem[rd_ptr_q];
            d_e_code = ec_mem[rd_ptr_q];
        end else if (bypass) begin
            d_valid  = 1'b1;
            d_pc     = if_pc_mem[if_rd_q];
            d_instr  = imem_rsp_data;
            d_e_code = 5'd0;
        end
    end

    assign fq_count = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if_rd_d    = if_rd_q;
        if_wr_d    = if_wr_q;

        if (redirect) begin
            // No request is accepted in a redirect cycle, so every outstanding
            // request not answered live this cycle becomes a stale response.
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            out_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if_rd_d    = '0;
            if_wr_d    = '0;
            drop_d     = drop_q - DCW'(rsp_drop) + DCW'(out_q) - DCW'(rsp_live);
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            out_d    = out_q + CW'(req_fire) - CW'(rsp_live);
            if_wr_d  = if_wr_q + PW'(req_fire);
            if_rd_d  = if_rd_q + PW'(rsp_live);
            drop_d   = drop_q - DCW'(rsp_drop);
            if (req_fire || exc_push) begin
                fetch_pc_d = fetch_pc_q + AW'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!mips_rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            if_rd_q    <= '0;
            if_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if_rd_q    <= if_rd_d;
            if_wr_q    <= if_wr_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= w_pc;
            instr_mem[wr_ptr_q] <= w_instr;
            ec_mem[wr_ptr_q]    <= w_ec;
        end
        if (req_fire) begin
            if_pc_mem[if_wr_q] <= fetch_pc_q;
        end
    end

endmodule
